// File: rtl/alu_arbiter_if.sv
// Bundles the request, ALU and response channels shared by alu_arbiter and its surroundings.
// slave is the arbiter's view; master is the requesters/ALU/consumer view.
`timescale 1ns/1ps

interface alu_arbiter_if #(
  parameter int WIDTH = 32
);

  // Request channel (two requesters)
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_operandA;
  logic [WIDTH-1:0] req0_operandB;
  logic [2:0]       req0_command;
  logic [WIDTH-1:0] req1_operandA;
  logic [WIDTH-1:0] req1_operandB;
  logic [2:0]       req1_command;

  // ALU channel
  logic [WIDTH-1:0] alu_operandA;
  logic [WIDTH-1:0] alu_operandB;
  logic [2:0]       alu_command;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carryout;
  logic             alu_zero;
  logic             alu_overflow;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_flags;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req0_operandA, req0_operandB, req0_command,
    input  req1_operandA, req1_operandB, req1_command,
    output alu_operandA, alu_operandB, alu_command,
    input  alu_result, alu_carryout, alu_zero, alu_overflow,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id, rsp_result, rsp_flags
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req0_operandA, req0_operandB, req0_command,
    output req1_operandA, req1_operandB, req1_command,
    input  alu_operandA, alu_operandB, alu_command,
    output alu_result, alu_carryout, alu_zero, alu_overflow,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id, rsp_result, rsp_flags
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; operands are held
// for SETTLE_CYCLES before result/flags are captured and returned tagged with the requester id.
`timescale 1ns/1ps

module alu_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state_q,      state_d;
    logic [3:0]       cnt_q,        cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             op_id_q,      op_id_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic [2:0]       alu_cmd_q,    alu_cmd_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [2:0]       rsp_flags_q,  rsp_flags_d;

    logic             grant_valid;
    logic             grant_id;
    logic [1:0]       req_ready_c;

    // Tie goes to the requester that was not served last; a lone request is granted directly.
    always_comb begin
        grant_valid = (state_q == IDLE) && (bus.req_valid != 2'b00);
        grant_id    = 1'b0;
        unique case (bus.req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant_q;
            default: grant_id = 1'b0;
        endcase
        req_ready_c = 2'b00;
        if (grant_valid) begin
            req_ready_c = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        op_id_d      = op_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cmd_d    = alu_cmd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_id) begin
                        alu_a_d   = bus.req1_operandA;
                        alu_b_d   = bus.req1_operandB;
                        alu_cmd_d = bus.req1_command;
                    end else begin
                        alu_a_d   = bus.req0_operandA;
                        alu_b_d   = bus.req0_operandB;
                        alu_cmd_d = bus.req0_command;
                    end
                    op_id_d      = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = SETTLE_LOAD;
                    state_d      = EXEC;
                end
            end

            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = bus.alu_result;
                    rsp_flags_d  = {bus.alu_carryout, bus.alu_zero, bus.alu_overflow};
                    rsp_id_d     = op_id_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            op_id_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cmd_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            op_id_q      <= op_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cmd_q    <= alu_cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.alu_operandA = alu_a_q;
    assign bus.alu_operandB = alu_b_q;
    assign bus.alu_command  = alu_cmd_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_flags    = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: three instances (SETTLE_CYCLES 2, 1, 15) each driving a behavioural ALU.
`timescale 1ns/1ps

module tb_alu_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus2  ();
    alu_arbiter_if #(.WIDTH(W)) bus1  ();
    alu_arbiter_if #(.WIDTH(W)) bus15 ();

    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(2))  dut     (.clk(clk), .reset(reset), .bus(bus2));
    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1))  dut_s1  (.clk(clk), .reset(reset), .bus(bus1));
    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(15)) dut_s15 (.clk(clk), .reset(reset), .bus(bus15));

    // Behavioural ALU: returns {result, carryout, zero, overflow}
    function automatic logic [W+2:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] cmd);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, o;
        c = 1'b0;
        o = 1'b0;
        r = '0;
        case (cmd)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0]; c = s[W];
                o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[W-1:0]; c = s[W];
                o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {r, c, (r == '0), o};
    endfunction

    assign {bus2.alu_result, bus2.alu_carryout, bus2.alu_zero, bus2.alu_overflow} =
        alu_f(bus2.alu_operandA, bus2.alu_operandB, bus2.alu_command);
    assign {bus1.alu_result, bus1.alu_carryout, bus1.alu_zero, bus1.alu_overflow} =
        alu_f(bus1.alu_operandA, bus1.alu_operandB, bus1.alu_command);
    assign {bus15.alu_result, bus15.alu_carryout, bus15.alu_zero, bus15.alu_overflow} =
        alu_f(bus15.alu_operandA, bus15.alu_operandB, bus15.alu_command);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " req_ready"},  64'(bus2.req_ready),    64'd0);
        check({tag, " rsp_valid"},  64'(bus2.rsp_valid),    64'd0);
        check({tag, " rsp_id"},     64'(bus2.rsp_id),       64'd0);
        check({tag, " rsp_result"}, 64'(bus2.rsp_result),   64'd0);
        check({tag, " rsp_flags"},  64'(bus2.rsp_flags),    64'd0);
        check({tag, " alu_A"},      64'(bus2.alu_operandA), 64'd0);
        check({tag, " alu_B"},      64'(bus2.alu_operandB), 64'd0);
        check({tag, " alu_cmd"},    64'(bus2.alu_command),  64'd0);
    endtask

    // Single operation on the SETTLE_CYCLES=2 instance; entered just after a rising edge.
    task automatic run_op(input string tag, input logic id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] cmd,
                          input logic [W-1:0] exp_r, input logic [2:0] exp_f);
        int  n;
        logic seen;
        if (id) begin
            bus2.req1_operandA = a; bus2.req1_operandB = b; bus2.req1_command = cmd;
            bus2.req_valid = 2'b10;
        end else begin
            bus2.req0_operandA = a; bus2.req0_operandB = b; bus2.req0_command = cmd;
            bus2.req_valid = 2'b01;
        end
        @(negedge clk);
        check({tag, " req_ready"}, 64'(bus2.req_ready), id ? 64'd2 : 64'd1);
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus2.rsp_valid) seen = 1'b1;
            else begin
                check({tag, " hold A"},   64'(bus2.alu_operandA), 64'(a));
                check({tag, " hold B"},   64'(bus2.alu_operandB), 64'(b));
                check({tag, " hold cmd"}, 64'(bus2.alu_command),  64'(cmd));
                check({tag, " busy ready"}, 64'(bus2.req_ready), 64'd0);
            end
        end
        check({tag, " latency"}, 64'(n), 64'd3);
        check({tag, " result"}, 64'(bus2.rsp_result), 64'(exp_r));
        check({tag, " flags"},  64'(bus2.rsp_flags),  64'(exp_f));
        check({tag, " id"},     64'(bus2.rsp_id),     64'(id));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " rsp drop"}, 64'(bus2.rsp_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n15;
        logic [W-1:0] r1, r15;

        reset = 1'b1;
        bus2.req_valid = '0;  bus1.req_valid = '0;  bus15.req_valid = '0;
        bus2.rsp_ready = 1'b1; bus1.rsp_ready = 1'b1; bus15.rsp_ready = 1'b1;
        bus2.req0_operandA = '0; bus2.req0_operandB = '0; bus2.req0_command = '0;
        bus2.req1_operandA = '0; bus2.req1_operandB = '0; bus2.req1_command = '0;
        bus1.req0_operandA = '0; bus1.req0_operandB = '0; bus1.req0_command = '0;
        bus1.req1_operandA = '0; bus1.req1_operandB = '0; bus1.req1_command = '0;
        bus15.req0_operandA = '0; bus15.req0_operandB = '0; bus15.req0_command = '0;
        bus15.req1_operandA = '0; bus15.req1_operandB = '0; bus15.req1_command = '0;
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("t1_add", 1'b0, 32'h1, 32'h1, 3'b000, 32'h2, 3'b000);
        run_op("t2_sub", 1'b1, 32'h5, 32'h5, 3'b001, 32'h0, 3'b110);

        // Both requesters pending from reset: grants must alternate 0,1,0,1
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus2.req0_operandA = 32'h3;  bus2.req0_operandB = 32'h4;  bus2.req0_command = 3'b000;
        bus2.req1_operandA = 32'hF0; bus2.req1_operandB = 32'h0F; bus2.req1_command = 3'b111;
        bus2.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3 grant", 64'(bus2.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge clk); #1;
            n = 0;
            while (!bus2.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t3 latency", 64'(n), 64'd3);
            check("t3 id", 64'(bus2.rsp_id), (k % 2 == 0) ? 64'd0 : 64'd1);
            check("t3 result", 64'(bus2.rsp_result), (k % 2 == 0) ? 64'h7 : 64'hFF);
            @(posedge clk); #1;
        end
        bus2.req_valid = 2'b00;
        @(posedge clk); #1;

        // Backpressure: overflowing add held for 10 cycles while req1 waits
        bus2.rsp_ready = 1'b0;
        bus2.req0_operandA = 32'h7FFF_FFFF; bus2.req0_operandB = 32'h1; bus2.req0_command = 3'b000;
        bus2.req_valid = 2'b01;
        @(negedge clk);
        check("t4 grant", 64'(bus2.req_ready), 64'd1);
        @(posedge clk); #1;
        bus2.req1_operandA = 32'hA; bus2.req1_operandB = 32'h3; bus2.req1_command = 3'b010;
        bus2.req_valid = 2'b11;
        n = 0;
        while (!bus2.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
            check("t4 exec ready", 64'(bus2.req_ready), 64'd0);
        end
        check("t4 latency", 64'(n), 64'd3);
        for (int i = 0; i < 10; i++) begin
            check("t4 hold valid",  64'(bus2.rsp_valid),  64'd1);
            check("t4 hold result", 64'(bus2.rsp_result), 64'h8000_0000);
            check("t4 hold flags",  64'(bus2.rsp_flags),  64'd1);
            check("t4 hold id",     64'(bus2.rsp_id),     64'd0);
            check("t4 hold ready",  64'(bus2.req_ready),  64'd0);
            @(posedge clk); #1;
            if (i < 9) @(negedge clk);
        end
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        check("t4 valid at ready rise", 64'(bus2.rsp_valid), 64'd1);
        @(negedge clk);
        check("t4 done", 64'(bus2.rsp_valid), 64'd0);
        check("t4 waiting req1 granted", 64'(bus2.req_ready), 64'd2);
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        n = 0;
        while (!bus2.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4 req1 id", 64'(bus2.rsp_id), 64'd1);
        check("t4 req1 result", 64'(bus2.rsp_result), 64'h9);
        check("t4 req1 flags", 64'(bus2.rsp_flags), 64'd0);
        @(posedge clk); #1;

        // Reset asserted mid-EXEC after a req0 grant
        bus2.req0_operandA = 32'h9; bus2.req0_operandB = 32'h9; bus2.req0_command = 3'b000;
        bus2.req_valid = 2'b01;
        @(negedge clk);
        check("t5 grant", 64'(bus2.req_ready), 64'd1);
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        #2 reset = 1'b1;
        #1 check_reset_vals("t5 async");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5 no rsp", 64'(bus2.rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        bus2.req_valid = 2'b11;
        @(negedge clk);
        check("t5 tie to req0", 64'(bus2.req_ready), 64'd1);
        bus2.req_valid = 2'b00;
        @(posedge clk); #1;

        // SETTLE_CYCLES 1 and 15, signed slt -1 < 1
        bus1.req0_operandA = 32'hFFFF_FFFF;  bus1.req0_operandB = 32'h1;  bus1.req0_command = 3'b011;
        bus15.req0_operandA = 32'hFFFF_FFFF; bus15.req0_operandB = 32'h1; bus15.req0_command = 3'b011;
        bus1.req_valid = 2'b01;
        bus15.req_valid = 2'b01;
        @(negedge clk);
        check("t6 s1 grant",  64'(bus1.req_ready),  64'd1);
        check("t6 s15 grant", 64'(bus15.req_ready), 64'd1);
        @(posedge clk); #1;
        bus1.req_valid = 2'b00;
        bus15.req_valid = 2'b00;
        n1 = 0; n15 = 0; r1 = '0; r15 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus1.rsp_valid && n1 == 0) begin n1 = c; r1 = bus1.rsp_result; end
            if (bus15.rsp_valid && n15 == 0) begin n15 = c; r15 = bus15.rsp_result; end
        end
        check("t6 s1 latency",  64'(n1),  64'd2);
        check("t6 s15 latency", 64'(n15), 64'd16);
        check("t6 s1 result",   64'(r1),  64'd1);
        check("t6 s15 result",  64'(r15), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
